// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states
// and a helper that picks out the multi-cycle ops.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // True for ops that occupy the unit for several cycles (mult/multu/div/divu).
  function automatic logic md_is_multi(input logic [2:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit multiply/divide result. res[63:32] goes to HI,
// res[31:0] to LO. Divisors are substituted with 1 on divide-by-zero and on
// signed overflow so the divider never sees an undefined case; the flags tell
// the sequencer what really happened.
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        div_zero,
  output logic        div_ovf
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] sa;
  logic signed [31:0] sb_safe;
  logic        [31:0] ub_safe;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;

  // Select the arithmetic result for the requested op.
  always_comb begin
    div_zero = (b == 32'd0);
    div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    sa       = $signed(a);
    sb_safe  = (div_zero || div_ovf) ? 32'sd1 : $signed(b);
    ub_safe  = div_zero ? 32'd1 : b;
    prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u   = {32'd0, a} * {32'd0, b};
    q_s      = sa / sb_safe;
    r_s      = sa % sb_safe;
    res      = 64'd0;
    case (op)
      MD_MULT:  res = $unsigned(prod_s);
      MD_MULTU: res = prod_u;
      MD_DIV:   res = {$unsigned(r_s), $unsigned(q_s)};
      MD_DIVU:  res = {a % ub_safe, a / ub_safe};
      default:  res = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide sequencer: owns HI/LO, times the multi-cycle unit with a
// down-counter and raises the ID-stage stall for HI/LO consumers.
//
// state   | meaning
// --------+-----------------------------------------------------------
// MD_IDLE | unit free; mthi/mtlo write directly, mult/div launch
// MD_RUN  | op in flight; cnt counts down, commit to HI/LO at cnt == 1
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use_ID,
  output logic        stall_md,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   state;
  md_state_e   state_nxt;
  logic [3:0]  cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_dz;
  logic [63:0] calc_res;
  logic        calc_dz;
  logic        calc_ovf;
  logic        launch;
  logic        retire;

  md_calc u_calc (
    .op       (md_op),
    .a        (a),
    .b        (b),
    .res      (calc_res),
    .div_zero (calc_dz),
    .div_ovf  (calc_ovf)
  );

  // Start while busy is ignored; only an idle unit accepts a new op.
  assign launch = (state == MD_IDLE) && start && md_is_multi(md_op);
  assign retire = (state == MD_RUN) && (cnt <= 4'd1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (launch) state_nxt = MD_RUN;
      MD_RUN:  if (retire) state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  // Outputs: busy follows the registered state; stall also covers an op that
  // is entering EX this cycle, before busy can show it.
  always_comb begin
    busy     = (state == MD_RUN);
    stall_md = md_use_ID & (busy | (start & md_is_multi(md_op)));
  end

  // Busy counter and pending result captured at launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_dz <= 1'b0;
    end else if (launch) begin
      cnt     <= ((md_op == MD_MULT) || (md_op == MD_MULTU)) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
      pend_hi <= calc_ovf ? 32'd0 : calc_res[63:32];
      pend_lo <= calc_ovf ? 32'h8000_0000 : calc_res[31:0];
      pend_dz <= calc_dz && ((md_op == MD_DIV) || (md_op == MD_DIVU));
    end else if (state == MD_RUN) begin
      cnt <= cnt - 4'd1;
    end
  end

  // HI/LO: direct moves while idle, pending result on retire (skipped on /0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (retire) begin
      if (!pend_dz) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if ((state == MD_IDLE) && start) begin
      if (md_op == MD_MTHI) hi <= a;
      if (md_op == MD_MTLO) lo <= a;
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: drives ops one at a time and checks busy
// duration, stall, and HI/LO against hand-computed values.
module tb_md_sched;
  import md_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_use_ID;
  logic        stall_md;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .md_op     (md_op),
    .a         (a),
    .b         (b),
    .md_use_ID (md_use_ID),
    .stall_md  (stall_md),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol guard: the pipeline must never present a start while busy.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(start && busy)) else begin
        failures++;
        $error("FAIL start_while_busy observed=1 expected=0");
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one op for a single cycle; checks the combinational stall before
  // the launching edge, then returns 1ns after that edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                       input logic use_id, input logic exp_stall);
    @(negedge clk);
    start     = 1'b1;
    md_op     = op;
    a         = va;
    b         = vb;
    md_use_ID = use_id;
    #1;
    check("stall_at_issue", {31'd0, stall_md}, {31'd0, exp_stall});
    @(posedge clk);
    #1;
    start = 1'b0;
    md_op = 3'd0;
  endtask

  // Busy must stay high for exactly n cycles after the launch edge.
  task automatic run_op(input int n, input logic exp_stall);
    for (int i = 0; i < n; i++) begin
      check("busy_high", {31'd0, busy}, 32'd1);
      check("stall_during", {31'd0, stall_md}, {31'd0, exp_stall});
      @(posedge clk);
      #1;
    end
    check("busy_low", {31'd0, busy}, 32'd0);
    check("stall_after", {31'd0, stall_md}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; md_op = 3'd0; a = 32'd0; b = 32'd0; md_use_ID = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall_md}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // mult -2 * 3 = -6
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    run_op(5, 1'b0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    // multu 0xFFFFFFFE * 3 = 0x2_FFFFFFFA
    issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    run_op(5, 1'b0);
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hFFFF_FFFA);

    // div -7 / 2 = -3 rem -1
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op(10, 1'b0);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_lo", lo, 32'hFFFF_FFFD);

    // divu 7 / 0: full latency, HI/LO untouched
    issue(MD_DIVU, 32'd7, 32'd0, 1'b0, 1'b0);
    run_op(10, 1'b0);
    check("divu0_hi", hi, 32'hFFFF_FFFF);
    check("divu0_lo", lo, 32'hFFFF_FFFD);

    // div 7 / -2 = -3 rem 1
    issue(MD_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op(10, 1'b0);
    check("div_neg_hi", hi, 32'h0000_0001);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);

    // divu 100 / 7 = 14 rem 2
    issue(MD_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    run_op(10, 1'b0);
    check("divu_hi", hi, 32'd2);
    check("divu_lo", lo, 32'd14);

    // signed overflow
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(10, 1'b0);
    check("ovf_hi", hi, 32'd0);
    check("ovf_lo", lo, 32'h8000_0000);

    // mult with mflo waiting in ID: stall from the issue cycle through busy
    issue(MD_MULT, 32'd6, 32'd7, 1'b1, 1'b1);
    run_op(5, 1'b1);
    check("mult_st_hi", hi, 32'd0);
    check("mult_st_lo", lo, 32'd42);

    // mtlo / mthi with a mover in ID: direct write, no busy, no stall
    issue(MD_MTLO, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
    check("mtlo_lo", lo, 32'h1234_5678);
    check("mtlo_hi", hi, 32'd0);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    check("mtlo_stall", {31'd0, stall_md}, 32'd0);
    issue(MD_MTHI, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0);
    check("mthi_hi", hi, 32'hCAFE_F00D);
    check("mthi_lo", lo, 32'h1234_5678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    md_use_ID = 1'b0;

    // op 7 has no effect
    issue(3'd7, 32'hDEAD_BEEF, 32'd1, 1'b0, 1'b0);
    check("op7_busy", {31'd0, busy}, 32'd0);
    check("op7_hi", hi, 32'hCAFE_F00D);
    check("op7_lo", lo, 32'h1234_5678);

    // reset in the middle of a divide: everything clears, nothing commits later
    issue(MD_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("post_hi", hi, 32'd0);
    check("post_lo", lo, 32'd0);
    check("post_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
